// File: rtl/uphw_mult_sequencer_if.sv
// rtl/uphw_mult_sequencer_if.sv - handshake and control bundle between sequencer and datapath
interface uphw_mult_sequencer_if;
  logic       start;
  logic       in_valid;
  logic       q_nz;
  logic       in_ack;
  logic [6:0] Control;
  logic       busy;
  logic       done;
  logic       err;

  // Driver side: issues start/operands and reports the datapath Z flag.
  modport master (
    output start,
    output in_valid,
    output q_nz,
    input  in_ack,
    input  Control,
    input  busy,
    input  done,
    input  err
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  in_valid,
    input  q_nz,
    output in_ack,
    output Control,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/uphw_mult_sequencer.sv
// rtl/uphw_mult_sequencer.sv - control sequencer computing R = M*Q mod 16 by repeated addition
module uphw_mult_sequencer #(
  parameter int MAX_ITER = 15,
  parameter int OUT_HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uphw_mult_sequencer_if.slave bus
);

  localparam int IW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
  localparam int HW = (OUT_HOLD < 2) ? 1 : $clog2(OUT_HOLD);

  localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(OUT_HOLD - 1);

  // Control word bit groups; exactly one group is driven per state.
  localparam logic [6:0] CTL_NONE   = 7'h00;
  localparam logic [6:0] CTL_OUT_EN = 7'h01;
  localparam logic [6:0] CTL_M_LOAD = 7'h02;
  localparam logic [6:0] CTL_R_CLR  = 7'h04;
  localparam logic [6:0] CTL_ADD    = 7'h18;
  localparam logic [6:0] CTL_R_LOAD = 7'h20;
  localparam logic [6:0] CTL_Q_LOAD = 7'h40;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_Q,
    S_CLR_R,
    S_CHECK,
    S_ADD_DEC,
    S_WRITE_R,
    S_OUT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] iter;
  logic [HW-1:0] hold;
  logic          err_q;
  logic          err_set;
  logic          err_clr;
  logic [6:0]    ctl_raw;
  logic          ack_raw;
  logic          busy_raw;
  logic          done_raw;

  // State register plus the pass counter, OUT hold counter and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      iter  <= '0;
      hold  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_CLR_R) begin
        iter <= '0;
      end else if (state == S_ADD_DEC) begin
        iter <= iter + IW'(1);
      end

      if (state == S_OUT && hold != HOLD_LAST) begin
        hold <= hold + HW'(1);
      end else begin
        hold <= '0;
      end

      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next-state and Moore control decode; only the LOAD states look at in_valid.
  always_comb begin
    state_nxt = state;
    ctl_raw   = CTL_NONE;
    ack_raw   = 1'b0;
    busy_raw  = 1'b1;
    done_raw  = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;

    unique case (state)
      S_IDLE: begin
        busy_raw = 1'b0;
        if (bus.start) begin
          state_nxt = S_LOAD_M;
          err_clr   = 1'b1;
        end
      end

      S_LOAD_M: begin
        if (bus.in_valid) begin
          ctl_raw   = CTL_M_LOAD;
          ack_raw   = 1'b1;
          state_nxt = S_LOAD_Q;
        end
      end

      S_LOAD_Q: begin
        if (bus.in_valid) begin
          ctl_raw   = CTL_Q_LOAD;
          ack_raw   = 1'b1;
          state_nxt = S_CLR_R;
        end
      end

      S_CLR_R: begin
        ctl_raw   = CTL_R_CLR;
        state_nxt = S_CHECK;
      end

      // q_nz here already reflects the decrement from the previous ADD_DEC edge.
      S_CHECK: begin
        if (!bus.q_nz) begin
          state_nxt = S_OUT;
        end else if (iter == ITER_LIMIT) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end else begin
          state_nxt = S_ADD_DEC;
        end
      end

      // ALU registers M+R while Q decrements on the same edge.
      S_ADD_DEC: begin
        ctl_raw   = CTL_ADD;
        state_nxt = S_WRITE_R;
      end

      // The ALU result registered last edge, so R can take it now.
      S_WRITE_R: begin
        ctl_raw   = CTL_R_LOAD;
        state_nxt = S_CHECK;
      end

      S_OUT: begin
        ctl_raw = CTL_OUT_EN;
        if (hold == HOLD_LAST) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done_raw  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // While reset is held nothing reaches the datapath, even before the first edge.
  assign bus.Control = rst_n ? ctl_raw  : CTL_NONE;
  assign bus.in_ack  = rst_n & ack_raw;
  assign bus.busy    = rst_n & busy_raw;
  assign bus.done    = rst_n & done_raw;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_uphw_mult_sequencer.sv
// tb/tb_uphw_mult_sequencer.sv - self-checking bench for the multiply sequencer
module tb_uphw_mult_sequencer;

  logic clk;
  logic rst_n;
  logic q_force;
  logic [3:0] in_bus;

  // Datapath plant driven by the Control word.
  logic [3:0] dp_m;
  logic [3:0] dp_q;
  logic [3:0] dp_r;
  logic [3:0] dp_a;

  int n_cmp;
  int n_fail;

  // Per-cycle logs and results of the most recent operation.
  logic [6:0] ctl_log  [0:255];
  logic       ack_log  [0:255];
  logic       busy_log [0:255];
  logic       err_log  [0:255];
  int         done_cyc;
  int         out_cyc;
  int         out_cnt;
  int         add_cnt;
  int         ack_total;
  logic [3:0] r_out;
  logic       err_at_done;
  logic       ctl_conflict;

  uphw_mult_sequencer_if bus ();

  uphw_mult_sequencer #(
    .MAX_ITER(15),
    .OUT_HOLD(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.Control[6]) dp_q <= in_bus;
    else if (bus.Control[4]) dp_q <= dp_q - 4'd1;
    if (bus.Control[1]) dp_m <= in_bus;
    if (bus.Control[3]) dp_a <= dp_m + dp_r;
    if (bus.Control[2]) dp_r <= 4'd0;
    else if (bus.Control[5]) dp_r <= dp_a;
  end

  assign bus.q_nz = q_force | (dp_q != 4'd0);

  // Runs one operation; cycle 0 is the cycle start is presented in IDLE.
  task automatic drive_op(input logic [3:0] m, input logic [3:0] q, input int stall,
                          input int busy_start, input int stop_at);
    int acks;
    acks = 0;
    done_cyc = -1; out_cyc = -1; out_cnt = 0; add_cnt = 0; ack_total = 0;
    r_out = 4'hx; err_at_done = 1'bx; ctl_conflict = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      bus.start    = (c == 0) || (c == busy_start);
      bus.in_valid = (c == 0) || (c > stall);
      in_bus       = (acks == 0) ? m : q;
      #1;
      ctl_log[c] = bus.Control; ack_log[c] = bus.in_ack;
      busy_log[c] = bus.busy; err_log[c] = bus.err;
      if (bus.in_ack) begin acks++; ack_total++; end
      if (bus.Control == 7'h18) add_cnt++;
      if (bus.Control[2] && bus.Control[5]) ctl_conflict = 1'b1;
      if (bus.Control[0]) begin
        out_cnt++;
        if (out_cyc < 0) begin out_cyc = c; r_out = dp_r; end
      end
      if (bus.done) begin done_cyc = c; err_at_done = bus.err; break; end
      if (c == stop_at) break;
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b1; bus.in_valid = 1'b1; in_bus = 4'h0; q_force = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.Control !== 7'h00) begin n_fail++; $display("FAIL reset_ctl_held got %h want 00", bus.Control); end
    bus.start = 1'b0; bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.Control !== 7'h00) begin n_fail++; $display("FAIL reset_ctl got %h want 00", bus.Control); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
  endtask

  task automatic test_basic_mult();
    drive_op(4'd3, 4'd4, 0, -1, -1);
    n_cmp++; if (done_cyc !== 18) begin n_fail++; $display("FAIL basic_done_cyc got %0d want 18", done_cyc); end
    n_cmp++; if (out_cyc !== 17) begin n_fail++; $display("FAIL basic_out_cyc got %0d want 17", out_cyc); end
    n_cmp++; if (r_out !== 4'd12) begin n_fail++; $display("FAIL basic_r got %0d want 12", r_out); end
    n_cmp++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", err_at_done); end
    n_cmp++; if (add_cnt !== 4) begin n_fail++; $display("FAIL basic_passes got %0d want 4", add_cnt); end
    n_cmp++; if (ack_total !== 2) begin n_fail++; $display("FAIL basic_acks got %0d want 2", ack_total); end
    n_cmp++; if (ctl_log[1] !== 7'h02 || ctl_log[2] !== 7'h40 || ctl_log[3] !== 7'h04) begin
      n_fail++; $display("FAIL basic_load_seq got %h %h %h want 02 40 04", ctl_log[1], ctl_log[2], ctl_log[3]); end
    n_cmp++; if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1 || busy_log[17] !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy got %b%b%b want 011", busy_log[0], busy_log[1], busy_log[17]); end
    n_cmp++; if (ctl_conflict !== 1'b0) begin n_fail++; $display("FAIL basic_clr_vs_load got %b want 0", ctl_conflict); end
  endtask

  task automatic test_corner_values();
    drive_op(4'd5, 4'd7, 0, -1, -1);
    n_cmp++; if (r_out !== 4'd3) begin n_fail++; $display("FAIL wrap_r got %0d want 3", r_out); end
    n_cmp++; if (done_cyc !== 27) begin n_fail++; $display("FAIL wrap_done_cyc got %0d want 27", done_cyc); end
    n_cmp++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b want 0", err_at_done); end
    drive_op(4'd9, 4'd0, 0, -1, -1);
    n_cmp++; if (r_out !== 4'd0) begin n_fail++; $display("FAIL qzero_r got %0d want 0", r_out); end
    n_cmp++; if (done_cyc !== 6) begin n_fail++; $display("FAIL qzero_done_cyc got %0d want 6", done_cyc); end
    n_cmp++; if (add_cnt !== 0) begin n_fail++; $display("FAIL qzero_passes got %0d want 0", add_cnt); end
  endtask

  task automatic test_load_stall();
    drive_op(4'd6, 4'd2, 3, -1, -1);
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (ctl_log[c] !== 7'h00 || ack_log[c] !== 1'b0) begin
        n_fail++; $display("FAIL stall_cyc%0d got ctl=%h ack=%b want 00/0", c, ctl_log[c], ack_log[c]); end
    end
    n_cmp++; if (ctl_log[4] !== 7'h02 || ack_log[4] !== 1'b1) begin
      n_fail++; $display("FAIL stall_accept got ctl=%h ack=%b want 02/1", ctl_log[4], ack_log[4]); end
    n_cmp++; if (ctl_log[5] !== 7'h40) begin n_fail++; $display("FAIL stall_next got %h want 40", ctl_log[5]); end
    n_cmp++; if (done_cyc !== 15 || r_out !== 4'd12) begin
      n_fail++; $display("FAIL stall_result got cyc=%0d r=%0d want 15/12", done_cyc, r_out); end
  endtask

  task automatic test_reset_mid_op();
    drive_op(4'd3, 4'd4, 0, -1, 5);
    n_cmp++; if (ctl_log[5] !== 7'h18) begin n_fail++; $display("FAIL midrst_in_add got %h want 18", ctl_log[5]); end
    rst_n = 1'b0; #1;
    n_cmp++; if (bus.Control !== 7'h00 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_immediate got ctl=%h busy=%b want 00/0", bus.Control, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_cmp++; if (bus.Control !== 7'h00 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle got ctl=%h busy=%b want 00/0", bus.Control, bus.busy); end
    drive_op(4'd2, 4'd2, 0, -1, -1);
    n_cmp++; if (r_out !== 4'd4 || done_cyc !== 12) begin
      n_fail++; $display("FAIL midrst_rerun got r=%0d cyc=%0d want 4/12", r_out, done_cyc); end
  endtask

  task automatic test_watchdog();
    q_force = 1'b1;
    drive_op(4'd1, 4'd3, 0, 10, -1);
    q_force = 1'b0;
    n_cmp++; if (done_cyc !== 50) begin n_fail++; $display("FAIL wdog_done_cyc got %0d want 50", done_cyc); end
    n_cmp++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL wdog_err got %b want 1", err_at_done); end
    n_cmp++; if (out_cnt !== 0) begin n_fail++; $display("FAIL wdog_out_en got %0d cycles want 0", out_cnt); end
    n_cmp++; if (add_cnt !== 15) begin n_fail++; $display("FAIL wdog_passes got %0d want 15", add_cnt); end
    @(negedge clk); #1;
    n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL wdog_err_hold got err=%b busy=%b want 1/0", bus.err, bus.busy); end
  endtask

  task automatic test_back_to_back();
    drive_op(4'd2, 4'd3, 0, -1, -1);
    n_cmp++; if (err_log[1] !== 1'b0 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_err_clear got %b/%b want 0/0", err_log[1], err_at_done); end
    n_cmp++; if (r_out !== 4'd6 || done_cyc !== 15) begin
      n_fail++; $display("FAIL b2b_first got r=%0d cyc=%0d want 6/15", r_out, done_cyc); end
    drive_op(4'd15, 4'd15, 0, -1, -1);
    n_cmp++; if (r_out !== 4'd1 || done_cyc !== 51 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_max got r=%0d cyc=%0d err=%b want 1/51/0", r_out, done_cyc, err_at_done); end
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic [3:0] q;
    int exp_r;
    for (int i = 0; i < 12; i++) begin
      m = 4'($urandom_range(0, 15));
      q = 4'($urandom_range(0, 15));
      exp_r = (int'(m) * int'(q)) % 16;
      drive_op(m, q, int'($urandom_range(0, 2)), -1, -1);
      n_cmp++; if (r_out !== 4'(exp_r)) begin
        n_fail++; $display("FAIL rand%0d_r m=%0d q=%0d got %0d want %0d", i, m, q, r_out, exp_r); end
      n_cmp++; if (add_cnt !== int'(q) || out_cnt !== 1) begin
        n_fail++; $display("FAIL rand%0d_shape got passes=%0d out=%0d want %0d/1", i, add_cnt, out_cnt, q); end
      n_cmp++; if (ack_total !== 2 || ctl_conflict !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_acks got acks=%0d conflict=%b want 2/0", i, ack_total, ctl_conflict); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    q_force = 1'b0;
    in_bus = 4'h0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    test_reset();
    test_basic_mult();
    test_corner_values();
    test_load_stall();
    test_reset_mid_op();
    test_watchdog();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
